id_decode_stage: RTL and testbench

- Instruction-decode stage of the out-of-order MIPS32 core.
- A combinational decoder takes the fetched pc/instruction, drives the register-file read interface, and produces operands, memory, CP0, branch and exception info.
- The result is registered in a pipeline register, with flush and stall control, before going to the ROB stage.
- The registered copy of "next is delay slot" feeds back to mark the following instruction as a delay slot.

---
 rtl/id_decode_stage_if.sv | 76 +++++++
 rtl/id_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_id_decode_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_decode_stage_if.sv
// Bundles the decode-stage bus: IF-side inputs, regfile read port and decoded outputs to the ROB stage.
// Latency: none; signal container only.
// Backpressure: carried as stall_current_stage/stall_next_stage levels, no handshake.
interface id_decode_stage_if #(
    parameter int GHR_WIDTH = 5
);
    logic                 flush;
    logic                 stall_current_stage;
    logic                 stall_next_stage;
    logic                 is_branch_taken_in;
    logic [GHR_WIDTH-1:0] pht_index_in;
    logic [31:0]          pc_in;
    logic [31:0]          inst_in;

    logic                 reg_read_en_1;
    logic                 reg_read_en_2;
    logic [4:0]           reg_read_addr_1;
    logic [4:0]           reg_read_addr_2;
    logic                 reg_read_is_ref_1;
    logic                 reg_read_is_ref_2;
    logic [31:0]          reg_read_data_1;
    logic [31:0]          reg_read_data_2;

    logic                 reg_write_en_out;
    logic [4:0]           reg_write_addr_out;
    logic                 is_branch_taken_out;
    logic [GHR_WIDTH-1:0] pht_index_out;
    logic [31:0]          inst_branch_target_out;
    logic                 mem_write_flag_out;
    logic                 mem_read_flag_out;
    logic                 mem_sign_ext_flag_out;
    logic [3:0]           mem_sel_out;
    logic [31:0]          mem_offset_out;
    logic                 cp0_read_flag_out;
    logic                 cp0_write_flag_out;
    logic [7:0]           cp0_addr_out;
    logic [3:0]           exception_type_out;
    logic                 is_current_delayslot_out;
    logic                 is_delayslot_out;
    logic [5:0]           opgen_out;
    logic                 operand_is_ref_1_out;
    logic                 operand_is_ref_2_out;
    logic [31:0]          operand_data_1_out;
    logic [31:0]          operand_data_2_out;
    logic [31:0]          pc_out;

    // Upstream / environment side: drives instruction, control and regfile data.
    modport master (
        output flush, stall_current_stage, stall_next_stage,
        output is_branch_taken_in, pht_index_in, pc_in, inst_in,
        input  reg_read_en_1, reg_read_en_2, reg_read_addr_1, reg_read_addr_2,
        output reg_read_is_ref_1, reg_read_is_ref_2, reg_read_data_1, reg_read_data_2,
        input  reg_write_en_out, reg_write_addr_out, is_branch_taken_out, pht_index_out,
        input  inst_branch_target_out, mem_write_flag_out, mem_read_flag_out,
        input  mem_sign_ext_flag_out, mem_sel_out, mem_offset_out,
        input  cp0_read_flag_out, cp0_write_flag_out, cp0_addr_out, exception_type_out,
        input  is_current_delayslot_out, is_delayslot_out, opgen_out,
        input  operand_is_ref_1_out, operand_is_ref_2_out,
        input  operand_data_1_out, operand_data_2_out, pc_out
    );

    // Decode stage side.
    modport slave (
        input  flush, stall_current_stage, stall_next_stage,
        input  is_branch_taken_in, pht_index_in, pc_in, inst_in,
        output reg_read_en_1, reg_read_en_2, reg_read_addr_1, reg_read_addr_2,
        input  reg_read_is_ref_1, reg_read_is_ref_2, reg_read_data_1, reg_read_data_2,
        output reg_write_en_out, reg_write_addr_out, is_branch_taken_out, pht_index_out,
        output inst_branch_target_out, mem_write_flag_out, mem_read_flag_out,
        output mem_sign_ext_flag_out, mem_sel_out, mem_offset_out,
        output cp0_read_flag_out, cp0_write_flag_out, cp0_addr_out, exception_type_out,
        output is_current_delayslot_out, is_delayslot_out, opgen_out,
        output operand_is_ref_1_out, operand_is_ref_2_out,
        output operand_data_1_out, operand_data_2_out, pc_out
    );
endinterface

// File: rtl/id_decode_stage.sv
// MIPS32 decode stage: decodes pc/inst into operands, memory, CP0, branch and exception info for the ROB stage.
// Latency: regfile read controls combinational; all decoded outputs registered, 1 cycle.
// Backpressure: both stalls hold the register; stall of this stage alone inserts a zero bubble.
module id_decode_stage #(
    parameter int GHR_WIDTH = 5
) (
    input logic              clk,
    input logic              rst,
    id_decode_stage_if.slave bus
);
    typedef struct packed {
        logic                 reg_write_en;
        logic [4:0]           reg_write_addr;
        logic                 is_branch_taken;
        logic [GHR_WIDTH-1:0] pht_index;
        logic [31:0]          branch_target;
        logic                 mem_write;
        logic                 mem_read;
        logic                 mem_sign_ext;
        logic [3:0]           mem_sel;
        logic [31:0]          mem_offset;
        logic                 cp0_read;
        logic                 cp0_write;
        logic [7:0]           cp0_addr;
        logic [3:0]           exception_type;
        logic                 is_next_delayslot;
        logic                 is_delayslot;
        logic [5:0]           opgen;
        logic                 op_is_ref_1;
        logic                 op_is_ref_2;
        logic [31:0]          op_data_1;
        logic [31:0]          op_data_2;
        logic [31:0]          pc;
    } dec_t;

    dec_t d;
    dec_t q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] index;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;

    logic        rd_en_1;
    logic        rd_en_2;
    logic [4:0]  rd_addr_1;
    logic [4:0]  rd_addr_2;
    logic [31:0] src_1;
    logic [31:0] src_2;
    logic        wen;
    logic [4:0]  waddr;

    assign opcode   = bus.inst_in[31:26];
    assign rs       = bus.inst_in[25:21];
    assign rt       = bus.inst_in[20:16];
    assign rd       = bus.inst_in[15:11];
    assign sa       = bus.inst_in[10:6];
    assign funct    = bus.inst_in[5:0];
    assign imm      = bus.inst_in[15:0];
    assign index    = bus.inst_in[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};
    assign pc_plus4 = bus.pc_in + 32'd4;
    assign pc_plus8 = bus.pc_in + 32'd8;

    // Register-register ALU funct codes; 0 means "not an R-type ALU op".
    function automatic logic [5:0] r_alu_opgen(input logic [5:0] f);
        case (f)
            6'b100001: r_alu_opgen = 6'd1;
            6'b100000: r_alu_opgen = 6'd2;
            6'b100011: r_alu_opgen = 6'd3;
            6'b100010: r_alu_opgen = 6'd4;
            6'b100100: r_alu_opgen = 6'd5;
            6'b100101: r_alu_opgen = 6'd6;
            6'b100110: r_alu_opgen = 6'd7;
            6'b100111: r_alu_opgen = 6'd8;
            6'b101010: r_alu_opgen = 6'd9;
            6'b101011: r_alu_opgen = 6'd10;
            default:   r_alu_opgen = 6'd0;
        endcase
    endfunction

    // Byte enables from the size bits shared by loads and stores (byte/half/word).
    function automatic logic [3:0] size_sel(input logic [1:0] s);
        case (s)
            2'b00:   size_sel = 4'b0001;
            2'b01:   size_sel = 4'b0011;
            default: size_sel = 4'b1111;
        endcase
    endfunction

    // Combinational decoder; shifts and MTC0 read rt through port 1 so operand 1 follows port 1's tag flag.
    always_comb begin
        d         = '0;
        rd_en_1   = 1'b0;
        rd_en_2   = 1'b0;
        rd_addr_1 = 5'd0;
        rd_addr_2 = 5'd0;
        src_1     = 32'd0;
        src_2     = 32'd0;
        wen       = 1'b0;
        waddr     = 5'd0;

        d.pc              = bus.pc_in;
        d.is_branch_taken = bus.is_branch_taken_in;
        d.pht_index       = bus.pht_index_in;
        d.is_delayslot    = q.is_next_delayslot;

        case (opcode)
            6'b000000: begin
                if (r_alu_opgen(funct) != 6'd0) begin
                    d.opgen   = r_alu_opgen(funct);
                    rd_en_1   = 1'b1;
                    rd_addr_1 = rs;
                    rd_en_2   = 1'b1;
                    rd_addr_2 = rt;
                    wen       = 1'b1;
                    waddr     = rd;
                end else begin
                    case (funct)
                        6'b000000, 6'b000010, 6'b000011: begin
                            d.opgen   = (funct == 6'b000000) ? 6'd11 :
                                        (funct == 6'b000010) ? 6'd12 : 6'd13;
                            rd_en_1   = 1'b1;
                            rd_addr_1 = rt;
                            src_2     = {27'd0, sa};
                            wen       = 1'b1;
                            waddr     = rd;
                        end
                        6'b001000, 6'b001001: begin
                            d.opgen             = 6'd18;
                            rd_en_1             = 1'b1;
                            rd_addr_1           = rs;
                            d.is_next_delayslot = 1'b1;
                            if (funct[0]) begin
                                wen   = 1'b1;
                                waddr = rd;
                                src_2 = pc_plus8;
                            end
                        end
                        6'b001100: begin
                            d.opgen          = 6'd23;
                            d.exception_type = 4'b0001;
                        end
                        6'b001101: begin
                            d.opgen          = 6'd24;
                            d.exception_type = 4'b0010;
                        end
                        default: d.exception_type = 4'b1000;
                    endcase
                end
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
                case (opcode[1:0])
                    2'b00:   d.opgen = 6'd2;
                    2'b01:   d.opgen = 6'd1;
                    2'b10:   d.opgen = 6'd9;
                    default: d.opgen = 6'd10;
                endcase
                rd_en_1   = 1'b1;
                rd_addr_1 = rs;
                src_2     = imm_sext;
                wen       = 1'b1;
                waddr     = rt;
            end
            6'b001100, 6'b001101, 6'b001110: begin
                d.opgen   = 6'd5 + {4'd0, opcode[1:0]};
                rd_en_1   = 1'b1;
                rd_addr_1 = rs;
                src_2     = imm_zext;
                wen       = 1'b1;
                waddr     = rt;
            end
            6'b001111: begin
                d.opgen = 6'd14;
                src_2   = {imm, 16'd0};
                wen     = 1'b1;
                waddr   = rt;
            end
            6'b000100, 6'b000101: begin
                d.opgen             = 6'd15 + {5'd0, opcode[0]};
                rd_en_1             = 1'b1;
                rd_addr_1           = rs;
                rd_en_2             = 1'b1;
                rd_addr_2           = rt;
                d.branch_target     = pc_plus4 + {imm_sext[29:0], 2'b00};
                d.is_next_delayslot = 1'b1;
            end
            6'b000010, 6'b000011: begin
                d.opgen             = 6'd17;
                d.branch_target     = {pc_plus4[31:28], index, 2'b00};
                d.is_next_delayslot = 1'b1;
                if (opcode[0]) begin
                    wen   = 1'b1;
                    waddr = 5'd31;
                    src_2 = pc_plus8;
                end
            end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                d.opgen        = 6'd19;
                d.mem_read     = 1'b1;
                d.mem_sel      = size_sel(opcode[1:0]);
                d.mem_sign_ext = !opcode[2] && (opcode[1:0] != 2'b11);
                d.mem_offset   = imm_sext;
                rd_en_1        = 1'b1;
                rd_addr_1      = rs;
                wen            = 1'b1;
                waddr          = rt;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                d.opgen      = 6'd20;
                d.mem_write  = 1'b1;
                d.mem_sel    = size_sel(opcode[1:0]);
                d.mem_offset = imm_sext;
                rd_en_1      = 1'b1;
                rd_addr_1    = rs;
                rd_en_2      = 1'b1;
                rd_addr_2    = rt;
            end
            6'b010000: begin
                case (rs)
                    5'b00000: begin
                        d.opgen    = 6'd21;
                        d.cp0_read = 1'b1;
                        d.cp0_addr = {rd, bus.inst_in[2:0]};
                        wen        = 1'b1;
                        waddr      = rt;
                    end
                    5'b00100: begin
                        d.opgen     = 6'd22;
                        d.cp0_write = 1'b1;
                        d.cp0_addr  = {rd, bus.inst_in[2:0]};
                        rd_en_1     = 1'b1;
                        rd_addr_1   = rt;
                    end
                    5'b10000: begin
                        if (funct == 6'b011000) begin
                            d.opgen          = 6'd25;
                            d.exception_type = 4'b0100;
                        end else begin
                            d.exception_type = 4'b1000;
                        end
                    end
                    default: d.exception_type = 4'b1000;
                endcase
            end
            default: d.exception_type = 4'b1000;
        endcase

        d.reg_write_en   = wen && (waddr != 5'd0);
        d.reg_write_addr = waddr;
        d.op_is_ref_1    = rd_en_1 & bus.reg_read_is_ref_1;
        d.op_is_ref_2    = rd_en_2 & bus.reg_read_is_ref_2;
        d.op_data_1      = rd_en_1 ? bus.reg_read_data_1 : src_1;
        d.op_data_2      = rd_en_2 ? bus.reg_read_data_2 : src_2;
    end

    // Pipeline register: bubble on reset/flush/stall of this stage only, hold when downstream also stalls.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || (bus.stall_current_stage && !bus.stall_next_stage)) begin
            q <= '0;
        end else if (!bus.stall_current_stage) begin
            q <= d;
        end
    end

    assign bus.reg_read_en_1   = rd_en_1;
    assign bus.reg_read_en_2   = rd_en_2;
    assign bus.reg_read_addr_1 = rd_addr_1;
    assign bus.reg_read_addr_2 = rd_addr_2;

    assign bus.reg_write_en_out         = q.reg_write_en;
    assign bus.reg_write_addr_out       = q.reg_write_addr;
    assign bus.is_branch_taken_out      = q.is_branch_taken;
    assign bus.pht_index_out            = q.pht_index;
    assign bus.inst_branch_target_out   = q.branch_target;
    assign bus.mem_write_flag_out       = q.mem_write;
    assign bus.mem_read_flag_out        = q.mem_read;
    assign bus.mem_sign_ext_flag_out    = q.mem_sign_ext;
    assign bus.mem_sel_out              = q.mem_sel;
    assign bus.mem_offset_out           = q.mem_offset;
    assign bus.cp0_read_flag_out        = q.cp0_read;
    assign bus.cp0_write_flag_out       = q.cp0_write;
    assign bus.cp0_addr_out             = q.cp0_addr;
    assign bus.exception_type_out       = q.exception_type;
    assign bus.is_current_delayslot_out = q.is_next_delayslot;
    assign bus.is_delayslot_out         = q.is_delayslot;
    assign bus.opgen_out                = q.opgen;
    assign bus.operand_is_ref_1_out     = q.op_is_ref_1;
    assign bus.operand_is_ref_2_out     = q.op_is_ref_2;
    assign bus.operand_data_1_out       = q.op_data_1;
    assign bus.operand_data_2_out       = q.op_data_2;
    assign bus.pc_out                   = q.pc;
endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: drives instructions, queues expected registered outputs, compares one cycle later.
// Latency: expects every decoded output one clock after the instruction is presented.
// Backpressure: exercises stall-both hold, stall-current bubble, flush and reset.
module tb_id_decode_stage;
    typedef struct packed {
        logic        wen;
        logic [4:0]  waddr;
        logic        bt;
        logic [4:0]  pht;
        logic [31:0] target;
        logic        mw;
        logic        mr;
        logic        msx;
        logic [3:0]  sel;
        logic [31:0] off;
        logic        c0r;
        logic        c0w;
        logic [7:0]  c0a;
        logic [3:0]  exc;
        logic        cur_ds;
        logic        ds;
        logic [5:0]  opgen;
        logic        ref1;
        logic        ref2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] pc;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_decode_stage_if #(.GHR_WIDTH(5)) bus ();
    id_decode_stage #(.GHR_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    out_t sb_q[$];
    logic       bt_cfg;
    logic [4:0] pht_cfg;
    out_t e;
    out_t held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.wen    = bus.reg_write_en_out;
        o.waddr  = bus.reg_write_addr_out;
        o.bt     = bus.is_branch_taken_out;
        o.pht    = bus.pht_index_out;
        o.target = bus.inst_branch_target_out;
        o.mw     = bus.mem_write_flag_out;
        o.mr     = bus.mem_read_flag_out;
        o.msx    = bus.mem_sign_ext_flag_out;
        o.sel    = bus.mem_sel_out;
        o.off    = bus.mem_offset_out;
        o.c0r    = bus.cp0_read_flag_out;
        o.c0w    = bus.cp0_write_flag_out;
        o.c0a    = bus.cp0_addr_out;
        o.exc    = bus.exception_type_out;
        o.cur_ds = bus.is_current_delayslot_out;
        o.ds     = bus.is_delayslot_out;
        o.opgen  = bus.opgen_out;
        o.ref1   = bus.operand_is_ref_1_out;
        o.ref2   = bus.operand_is_ref_2_out;
        o.op1    = bus.operand_data_1_out;
        o.op2    = bus.operand_data_2_out;
        o.pc     = bus.pc_out;
        return o;
    endfunction

    task automatic compare_all(input string tag, input out_t g, input out_t x);
        check({tag, "/wen"},    32'(g.wen),    32'(x.wen));
        check({tag, "/waddr"},  32'(g.waddr),  32'(x.waddr));
        check({tag, "/bt"},     32'(g.bt),     32'(x.bt));
        check({tag, "/pht"},    32'(g.pht),    32'(x.pht));
        check({tag, "/target"}, g.target,      x.target);
        check({tag, "/mw"},     32'(g.mw),     32'(x.mw));
        check({tag, "/mr"},     32'(g.mr),     32'(x.mr));
        check({tag, "/msx"},    32'(g.msx),    32'(x.msx));
        check({tag, "/sel"},    32'(g.sel),    32'(x.sel));
        check({tag, "/off"},    g.off,         x.off);
        check({tag, "/c0r"},    32'(g.c0r),    32'(x.c0r));
        check({tag, "/c0w"},    32'(g.c0w),    32'(x.c0w));
        check({tag, "/c0a"},    32'(g.c0a),    32'(x.c0a));
        check({tag, "/exc"},    32'(g.exc),    32'(x.exc));
        check({tag, "/cur_ds"}, 32'(g.cur_ds), 32'(x.cur_ds));
        check({tag, "/ds"},     32'(g.ds),     32'(x.ds));
        check({tag, "/opgen"},  32'(g.opgen),  32'(x.opgen));
        check({tag, "/ref1"},   32'(g.ref1),   32'(x.ref1));
        check({tag, "/ref2"},   32'(g.ref2),   32'(x.ref2));
        check({tag, "/op1"},    g.op1,         x.op1);
        check({tag, "/op2"},    g.op2,         x.op2);
        check({tag, "/pc"},     g.pc,          x.pc);
    endtask

    function automatic out_t base(input logic [31:0] pc, input logic ds, input logic cur_ds);
        out_t o;
        o        = '0;
        o.pc     = pc;
        o.bt     = bt_cfg;
        o.pht    = pht_cfg;
        o.ds     = ds;
        o.cur_ds = cur_ds;
        return o;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] d1, input logic r1,
                         input logic [31:0] d2, input logic r2);
        bus.pc_in              = pc;
        bus.inst_in            = inst;
        bus.reg_read_data_1    = d1;
        bus.reg_read_is_ref_1  = r1;
        bus.reg_read_data_2    = d2;
        bus.reg_read_is_ref_2  = r2;
        bus.is_branch_taken_in = bt_cfg;
        bus.pht_index_in       = pht_cfg;
    endtask

    task automatic step(input string tag, input out_t x);
        out_t got;
        out_t exp;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        got = sample();
        exp = sb_q.pop_front();
        compare_all(tag, got, exp);
    endtask

    task automatic issue(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] d1, input logic r1,
                         input logic [31:0] d2, input logic r2, input out_t x);
        drive(pc, inst, d1, r1, d2, r2);
        step(tag, x);
    endtask

    initial begin
        rst                     = 1'b1;
        bus.flush               = 1'b0;
        bus.stall_current_stage = 1'b0;
        bus.stall_next_stage    = 1'b0;
        bt_cfg                  = 1'b0;
        pht_cfg                 = 5'd0;

        issue("reset", 32'hbfc00000, 32'h90001234, 32'h12345678, 1'b0, 32'h0, 1'b0, '0);
        rst = 1'b0;

        // LBU, with combinational regfile read checks
        drive(32'hbfc00000, 32'h90001234, 32'h12345678, 1'b0, 32'h0, 1'b0);
        #1;
        check("lbu_rd_en1", 32'(bus.reg_read_en_1), 32'd1);
        check("lbu_rd_en2", 32'(bus.reg_read_en_2), 32'd0);
        e = base(32'hbfc00000, 1'b0, 1'b0);
        e.mr = 1'b1; e.sel = 4'b0001; e.off = 32'h00001234; e.opgen = 6'd19; e.op1 = 32'h12345678;
        step("lbu", e);

        e = base(32'hbfc00004, 1'b0, 1'b0);
        e.mw = 1'b1; e.sel = 4'b1111; e.off = 32'h00001234; e.opgen = 6'd20;
        e.op1 = 32'h12345678; e.op2 = 32'habcdef00;
        issue("sw", 32'hbfc00004, 32'hac001234, 32'h12345678, 1'b0, 32'habcdef00, 1'b0, e);

        e = base(32'hbfc00008, 1'b0, 1'b1);
        e.target = 32'hb048d158; e.wen = 1'b1; e.waddr = 5'd31; e.op2 = 32'hbfc00010; e.opgen = 6'd17;
        issue("jal", 32'hbfc00008, 32'h0c123456, 32'h55555555, 1'b1, 32'h66666666, 1'b1, e);

        e = base(32'hbfc0000c, 1'b1, 1'b1);
        e.wen = 1'b1; e.waddr = 5'd10; e.op1 = 32'h11112222; e.ref1 = 1'b1; e.op2 = 32'hbfc00014; e.opgen = 6'd18;
        issue("jalr", 32'hbfc0000c, 32'h00005009, 32'h11112222, 1'b1, 32'h0, 1'b0, e);

        bt_cfg  = 1'b1;
        pht_cfg = 5'h15;
        e = base(32'hbfc00010, 1'b1, 1'b1);
        e.target = 32'hbfc048e4; e.op1 = 32'h5; e.op2 = 32'h6; e.ref2 = 1'b1; e.opgen = 6'd16;
        issue("bne", 32'hbfc00010, 32'h14001234, 32'h5, 1'b0, 32'h6, 1'b1, e);

        e = base(32'hbfc00014, 1'b1, 1'b0);
        e.c0r = 1'b1; e.c0a = 8'h55; e.opgen = 6'd21;
        issue("mfc0", 32'hbfc00014, 32'h40005005, 32'h7, 1'b1, 32'h8, 1'b1, e);
        bt_cfg  = 1'b0;
        pht_cfg = 5'd0;

        e = base(32'hbfc00018, 1'b0, 1'b0);
        e.wen = 1'b1; e.waddr = 5'd8; e.op1 = 32'h100; e.op2 = 32'hffffcdef; e.opgen = 6'd1;
        issue("addiu", 32'hbfc00018, 32'h2408cdef, 32'h100, 1'b0, 32'h0, 1'b0, e);

        e = base(32'hbfc0001c, 1'b0, 1'b0);
        e.exc = 4'b1000;
        issue("invalid", 32'hbfc0001c, 32'hffffffff, 32'h9, 1'b1, 32'ha, 1'b1, e);

        e = base(32'hbfc00020, 1'b0, 1'b0);
        e.wen = 1'b1; e.waddr = 5'd9; e.op1 = 32'h0f0f0000; e.op2 = 32'h0000f0f0; e.opgen = 6'd6;
        issue("ori", 32'hbfc00020, 32'h3509f0f0, 32'h0f0f0000, 1'b0, 32'h0, 1'b0, e);

        // SLL reads rt as operand 1
        drive(32'hbfc00024, 32'h00094080, 32'h80000001, 1'b0, 32'h0, 1'b0);
        #1;
        check("sll_rd_addr1", 32'(bus.reg_read_addr_1), 32'd9);
        check("sll_rd_en2", 32'(bus.reg_read_en_2), 32'd0);
        e = base(32'hbfc00024, 1'b0, 1'b0);
        e.wen = 1'b1; e.waddr = 5'd8; e.op1 = 32'h80000001; e.op2 = 32'd2; e.opgen = 6'd11;
        step("sll", e);

        e = base(32'hbfc00028, 1'b0, 1'b0);
        e.mr = 1'b1; e.sel = 4'b0001; e.msx = 1'b1; e.off = 32'hfffffffc;
        e.wen = 1'b1; e.waddr = 5'd9; e.op1 = 32'h1000; e.opgen = 6'd19;
        issue("lb", 32'hbfc00028, 32'h8109fffc, 32'h1000, 1'b0, 32'h0, 1'b0, e);

        e = base(32'hbfc0002c, 1'b0, 1'b0);
        e.exc = 4'b0001; e.opgen = 6'd23;
        issue("syscall", 32'hbfc0002c, 32'h0000000c, 32'h0, 1'b0, 32'h0, 1'b0, e);

        e = base(32'hbfc00030, 1'b0, 1'b0);
        e.exc = 4'b0100; e.opgen = 6'd25;
        issue("eret", 32'hbfc00030, 32'h42000018, 32'h0, 1'b0, 32'h0, 1'b0, e);

        e = base(32'hbfc00034, 1'b0, 1'b1);
        e.target = 32'hb048d158; e.wen = 1'b1; e.waddr = 5'd31; e.op2 = 32'hbfc0003c; e.opgen = 6'd17;
        issue("jal2", 32'hbfc00034, 32'h0c123456, 32'h0, 1'b0, 32'h0, 1'b0, e);
        held = e;

        bus.stall_current_stage = 1'b1;
        bus.stall_next_stage    = 1'b1;
        issue("hold1", 32'hbfc00038, 32'h2408cdef, 32'h3, 1'b0, 32'h0, 1'b0, held);
        issue("hold2", 32'hbfc00038, 32'h2408cdef, 32'h3, 1'b0, 32'h0, 1'b0, held);
        bus.stall_current_stage = 1'b0;
        bus.stall_next_stage    = 1'b0;

        e = base(32'hbfc00038, 1'b1, 1'b0);
        e.wen = 1'b1; e.waddr = 5'd8; e.op1 = 32'h3; e.op2 = 32'hffffcdef; e.opgen = 6'd1;
        issue("after_hold", 32'hbfc00038, 32'h2408cdef, 32'h3, 1'b0, 32'h0, 1'b0, e);

        e = base(32'hbfc0003c, 1'b0, 1'b1);
        e.target = 32'hbfc00038; e.op1 = 32'h11; e.op2 = 32'h22; e.opgen = 6'd15;
        issue("beq", 32'hbfc0003c, 32'h1109fffe, 32'h11, 1'b0, 32'h22, 1'b0, e);

        bus.stall_current_stage = 1'b1;
        issue("bubble", 32'hbfc00040, 32'h2408cdef, 32'h4, 1'b0, 32'h0, 1'b0, '0);
        bus.stall_current_stage = 1'b0;

        e = base(32'hbfc00040, 1'b0, 1'b0);
        e.wen = 1'b1; e.waddr = 5'd8; e.op1 = 32'h4; e.op2 = 32'hffffcdef; e.opgen = 6'd1;
        issue("after_bubble", 32'hbfc00040, 32'h2408cdef, 32'h4, 1'b0, 32'h0, 1'b0, e);

        bus.flush = 1'b1;
        issue("flush", 32'hbfc00044, 32'h2408cdef, 32'h5, 1'b0, 32'h0, 1'b0, '0);
        bus.flush = 1'b0;

        e = base(32'hbfc00048, 1'b0, 1'b0);
        e.wen = 1'b1; e.waddr = 5'd8; e.op1 = 32'h6; e.op2 = 32'hffffcdef; e.opgen = 6'd1;
        issue("after_flush", 32'hbfc00048, 32'h2408cdef, 32'h6, 1'b0, 32'h0, 1'b0, e);

        rst = 1'b1;
        issue("rst_mid", 32'hbfc0004c, 32'h2408cdef, 32'h7, 1'b0, 32'h0, 1'b0, '0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
